// File: rtl/ins_fetch_issue_if.sv
// Fetch/issue bus: instruction memory port, decode handshake and redirect.
interface ins_fetch_issue_if #(
   parameter int unsigned PC_W = 8
);
   logic [PC_W-1:0] imem_addr;
   logic            imem_rd_en;
   logic [19:0]     imem_data;
   logic            stall;
   logic            redirect;
   logic [PC_W-1:0] redirect_pc;
   logic [19:0]     ins;
   logic            ins_valid;
   logic [PC_W-1:0] ins_pc;
   logic            halted;

   // Fetch unit side
   modport master (
      output imem_addr, imem_rd_en, ins, ins_valid, ins_pc, halted,
      input  imem_data, stall, redirect, redirect_pc
   );

   // Memory / decode / branch side
   modport slave (
      input  imem_addr, imem_rd_en, ins, ins_valid, ins_pc, halted,
      output imem_data, stall, redirect, redirect_pc
   );
endinterface

// File: rtl/ins_fetch_issue.sv
// Instruction fetch/issue front end: PC, 1-cycle synchronous imem read,
// DEPTH-entry prefetch FIFO and a registered issue stage.
module ins_fetch_issue #(
   parameter int unsigned    PC_W     = 8,
   parameter int unsigned    DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter logic [4:0]     HALT_OP  = 5'b11111
) (
   input logic            clk,
   input logic            reset,
   ins_fetch_issue_if.master bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic [19:0]     word;
      logic [PC_W-1:0] pc;
   } entry_t;

   logic [PC_W-1:0] pc_q, pc_d;
   logic            inflight_q, inflight_d;
   logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
   logic            halted_q, halted_d;
   logic [CW-1:0]   count_q, count_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   entry_t          fifo_q [DEPTH];
   entry_t          fifo_d [DEPTH];
   logic [19:0]     ins_q, ins_d;
   logic            ins_valid_q, ins_valid_d;
   logic [PC_W-1:0] ins_pc_q, ins_pc_d;

   logic            halt_hit;
   logic            rd_en;
   logic            push;
   logic            pop;
   logic [CW-1:0]   occupancy;
   entry_t          head;

   // Fetch gating: never request more words than the FIFO can absorb
   always_comb begin
      halt_hit  = inflight_q && (bus.imem_data[19:15] == HALT_OP);
      occupancy = count_q + CW'(inflight_q);
      rd_en     = !reset && !bus.redirect && !halted_q && !halt_hit &&
                  (occupancy < CW'(DEPTH));
      push      = inflight_q && !bus.redirect;
      pop       = !bus.stall && !bus.redirect && (count_q != '0);
      head      = fifo_q[rd_ptr_q];
   end

   // Next-state: redirect flushes everything, otherwise fetch/push/issue
   always_comb begin
      pc_d          = pc_q;
      inflight_d    = rd_en;
      inflight_pc_d = inflight_pc_q;
      halted_d      = halted_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      fifo_d        = fifo_q;
      ins_d         = ins_q;
      ins_valid_d   = ins_valid_q;
      ins_pc_d      = ins_pc_q;

      if (bus.redirect) begin
         pc_d        = bus.redirect_pc;
         inflight_d  = 1'b0;
         halted_d    = 1'b0;
         count_d     = '0;
         rd_ptr_d    = '0;
         wr_ptr_d    = '0;
         ins_d       = '0;
         ins_valid_d = 1'b0;
      end else begin
         if (rd_en) begin
            pc_d          = pc_q + PC_W'(1);
            inflight_pc_d = pc_q;
         end
         if (push) begin
            fifo_d[wr_ptr_q] = '{word: bus.imem_data, pc: inflight_pc_q};
            wr_ptr_d         = wr_ptr_q + AW'(1);
            if (halt_hit) begin
               halted_d = 1'b1;
            end
         end
         if (!bus.stall) begin
            if (pop) begin
               ins_d       = head.word;
               ins_pc_d    = head.pc;
               ins_valid_d = 1'b1;
               rd_ptr_d    = rd_ptr_q + AW'(1);
            end else begin
               ins_d       = '0;
               ins_valid_d = 1'b0;
            end
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // Control and issue registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         halted_q      <= 1'b0;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         ins_q         <= '0;
         ins_valid_q   <= 1'b0;
         ins_pc_q      <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         halted_q      <= halted_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         ins_q         <= ins_d;
         ins_valid_q   <= ins_valid_d;
         ins_pc_q      <= ins_pc_d;
      end
   end

   // FIFO storage needs no reset: count gates every read
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

   assign bus.imem_addr  = pc_q;
   assign bus.imem_rd_en = rd_en;
   assign bus.ins        = ins_q;
   assign bus.ins_valid  = ins_valid_q;
   assign bus.ins_pc     = ins_pc_q;
   assign bus.halted     = halted_q;
endmodule
